// File: rtl/axi_ethernet_v3_01_a_axi_lite_ipic_bridge.sv
// rtl/axi_ethernet_v3_01_a_axi_lite_ipic_bridge.sv - AXI4-Lite slave to IPIC bridge, one transaction in flight
module axi_ethernet_v3_01_a_axi_lite_ipic_bridge #(
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_TIMEOUT_CYCLES   = 64
) (
    input  logic                          bus2ip_clk,
    input  logic                          bus2ip_reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [31:0]                   s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [31:0]                   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [C_S_AXI_ADDR_WIDTH-1:0] bus2ip_addr,
    output logic [31:0]                   bus2ip_data,
    output logic [3:0]                    bus2ip_be,
    output logic                          bus2ip_cs,
    output logic                          bus2ip_rdce,
    output logic                          bus2ip_wrce,
    input  logic                          ip2bus_rdack,
    input  logic                          ip2bus_wrack,
    input  logic                          ip2bus_error,
    input  logic [31:0]                   ip2bus_data
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(C_TIMEOUT_CYCLES - 1);

    state_t                          state_q, state_d;
    logic                            is_wr_q, is_wr_d;
    logic                            last_wr_q, last_wr_d;
    logic [7:0]                      timer_q, timer_d;
    logic                            awready_q, awready_d;
    logic                            wready_q, wready_d;
    logic                            arready_q, arready_d;
    logic                            bvalid_q, bvalid_d;
    logic [1:0]                      bresp_q, bresp_d;
    logic                            rvalid_q, rvalid_d;
    logic [1:0]                      rresp_q, rresp_d;
    logic [31:0]                     rdata_q, rdata_d;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]                     data_q, data_d;
    logic [3:0]                      be_q, be_d;
    logic                            cs_q, cs_d;
    logic                            rdce_q, rdce_d;
    logic                            wrce_q, wrce_d;

    logic wr_elig, rd_elig, grant_rd, grant_wr, ack, timeout, resp_done;
    logic [1:0] resp;

    // Round-robin: a contested grant goes to whichever type did not win last
    assign wr_elig   = s_axi_awvalid && s_axi_wvalid;
    assign rd_elig   = s_axi_arvalid;
    assign grant_rd  = rd_elig && (!wr_elig || last_wr_q);
    assign grant_wr  = wr_elig && !grant_rd;
    assign ack       = is_wr_q ? ip2bus_wrack : ip2bus_rdack;
    assign timeout   = (timer_q == TIMEOUT_LAST);
    assign resp      = (!ack || ip2bus_error) ? 2'b10 : 2'b00;
    assign resp_done = is_wr_q ? s_axi_bready : s_axi_rready;

    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_reset) begin
            state_q   <= ST_IDLE;
            is_wr_q   <= 1'b0;
            last_wr_q <= 1'b1;
            timer_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            cs_q      <= 1'b0;
            rdce_q    <= 1'b0;
            wrce_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            last_wr_q <= last_wr_d;
            timer_q   <= timer_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            be_q      <= be_d;
            cs_q      <= cs_d;
            rdce_q    <= rdce_d;
            wrce_q    <= wrce_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (grant_rd || grant_wr) state_d = ST_ACCESS;
            ST_ACCESS: if (ack || timeout)       state_d = ST_RESP;
            ST_RESP:   if (resp_done)            state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        arready_d = 1'b0;
        is_wr_d   = is_wr_q;
        last_wr_d = last_wr_q;
        timer_d   = timer_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        data_d    = data_q;
        be_d      = be_q;
        cs_d      = cs_q;
        rdce_d    = rdce_q;
        wrce_d    = wrce_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_rd) begin
                    arready_d = 1'b1;
                    addr_d    = s_axi_araddr;
                    cs_d      = 1'b1;
                    rdce_d    = 1'b1;
                    is_wr_d   = 1'b0;
                    last_wr_d = 1'b0;
                    timer_d   = '0;
                end else if (grant_wr) begin
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    addr_d    = s_axi_awaddr;
                    data_d    = s_axi_wdata;
                    be_d      = s_axi_wstrb;
                    cs_d      = 1'b1;
                    wrce_d    = 1'b1;
                    is_wr_d   = 1'b1;
                    last_wr_d = 1'b1;
                    timer_d   = '0;
                end
            end
            ST_ACCESS: begin
                timer_d = timer_q + 8'd1;
                // An ack on the final timer cycle still wins over the timeout
                if (ack || timeout) begin
                    cs_d   = 1'b0;
                    rdce_d = 1'b0;
                    wrce_d = 1'b0;
                    if (is_wr_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = resp;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = resp;
                        rdata_d  = (ack && !ip2bus_error) ? ip2bus_data : 32'h0;
                    end
                end
            end
            ST_RESP: begin
                if (is_wr_q && s_axi_bready)   bvalid_d = 1'b0;
                if (!is_wr_q && s_axi_rready)  rvalid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_arready = arready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign bus2ip_addr   = addr_q;
    assign bus2ip_data   = data_q;
    assign bus2ip_be     = be_q;
    assign bus2ip_cs     = cs_q;
    assign bus2ip_rdce   = rdce_q;
    assign bus2ip_wrce   = wrce_q;

endmodule

// File: tb/tb_axi_ethernet_v3_01_a_axi_lite_ipic_bridge.sv
// tb/tb_axi_ethernet_v3_01_a_axi_lite_ipic_bridge.sv - directed scoreboard bench for the AXI-Lite/IPIC bridge
module tb_axi_ethernet_v3_01_a_axi_lite_ipic_bridge;

    localparam int AW = 12;

    typedef struct packed {
        logic        is_wr;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, wvalid, arvalid, bready, rready;
    logic [31:0]   wdata, ipdata;
    logic [3:0]    wstrb;
    logic          rdack, wrack, err;
    logic          awready, wready, arready, bvalid, rvalid;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata, bus_data;
    logic [AW-1:0] bus_addr;
    logic [3:0]    bus_be;
    logic          cs, rdce, wrce;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic g;
    int   n;

    axi_ethernet_v3_01_a_axi_lite_ipic_bridge #(
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_TIMEOUT_CYCLES(64)
    ) dut (
        .bus2ip_clk(clk),       .bus2ip_reset(rst),
        .s_axi_awaddr(awaddr),  .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata),    .s_axi_wstrb(wstrb),     .s_axi_wvalid(wvalid),  .s_axi_wready(wready),
        .s_axi_bresp(bresp),    .s_axi_bvalid(bvalid),   .s_axi_bready(bready),
        .s_axi_araddr(araddr),  .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata),    .s_axi_rresp(rresp),     .s_axi_rvalid(rvalid),  .s_axi_rready(rready),
        .bus2ip_addr(bus_addr), .bus2ip_data(bus_data),  .bus2ip_be(bus_be),
        .bus2ip_cs(cs),         .bus2ip_rdce(rdce),      .bus2ip_wrce(wrce),
        .ip2bus_rdack(rdack),   .ip2bus_wrack(wrack),    .ip2bus_error(err),     .ip2bus_data(ipdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic w, input logic [1:0] r, input logic [31:0] d);
        exp_t e;
        e.is_wr = w;
        e.resp  = r;
        e.data  = d;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic w, input logic [1:0] r, input logic [31:0] d);
        exp_t e;
        chk("sb_has_entry", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp_kind", 32'(w), 32'(e.is_wr));
            chk("resp_code", 32'(r), 32'(e.resp));
            if (!w) chk("resp_rdata", d, e.data);
        end
    endtask

    // Responses are scored on the handshake cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && bvalid && bready) pop_check(1'b1, bresp, 32'h0);
        if (!rst && rvalid && rready) pop_check(1'b0, rresp, rdata);
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"},  32'({awready, wready, arready, bvalid, rvalid, cs, rdce, wrce}), 0);
        chk({tag, "_resp"}, 32'({bresp, rresp}), 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_addr"}, 32'(bus_addr), 0);
        chk({tag, "_data"}, bus_data, 0);
        chk({tag, "_be"},   32'(bus_be), 0);
    endtask

    task automatic wait_grant(output logic is_rd);
        logic found;
        found = 1'b0;
        is_rd = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (arready || awready) begin
                found = 1'b1;
                is_rd = arready;
            end
        end
        chk("grant_seen", 32'(found), 1);
    endtask

    task automatic wait_quiet();
        logic quiet;
        quiet = 1'b0;
        for (int i = 0; i < 50 && !quiet; i++) begin
            if (!bvalid && !rvalid) quiet = 1'b1;
            else tick();
        end
        chk("resp_retired", 32'(quiet), 1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int ack_at, input logic e, input logic stray);
        logic gr;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        push_exp(1'b1, e ? 2'b10 : 2'b00, 32'h0);
        wait_grant(gr);
        chk("wr_grant_type", 32'(gr), 0);
        chk("wr_ready_pair", 32'({awready, wready}), 32'h3);
        chk("wr_addr", 32'(bus_addr), 32'(a));
        chk("wr_data", bus_data, d);
        chk("wr_be", 32'(bus_be), 32'(s));
        for (int i = 1; i <= ack_at; i++) begin
            chk("wr_ce_held", 32'({cs, wrce, rdce}), 32'h6);
            if (i == ack_at) begin
                wrack = 1'b1; err = e;
            end else begin
                rdack = stray;
            end
            tick();
            awvalid = 1'b0; wvalid = 1'b0; rdack = 1'b0; wrack = 1'b0; err = 1'b0;
            if (i == 1 && ack_at > 1) chk("wr_ready_one_cycle", 32'({awready, wready}), 0);
        end
        chk("wr_ce_drop", 32'({cs, wrce, rdce}), 0);
        chk("wr_bvalid", 32'(bvalid), 1);
        chk("wr_bresp", 32'(bresp), e ? 32'h2 : 32'h0);
        wait_quiet();
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int ack_at, input logic [31:0] d);
        logic gr;
        araddr = a; arvalid = 1'b1;
        push_exp(1'b0, 2'b00, d);
        wait_grant(gr);
        chk("rd_grant_type", 32'(gr), 1);
        chk("rd_addr", 32'(bus_addr), 32'(a));
        for (int i = 1; i < ack_at; i++) begin
            tick();
            arvalid = 1'b0;
        end
        rdack = 1'b1; ipdata = d;
        tick();
        rdack = 1'b0; arvalid = 1'b0; ipdata = 32'h0;
        chk("rd_rvalid", 32'(rvalid), 1);
        wait_quiet();
    endtask

    initial begin
        rst = 1'b1; awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wdata = '0; wstrb = '0; bready = 1'b1; rready = 1'b1;
        rdack = 1'b0; wrack = 1'b0; err = 1'b0; ipdata = '0;

        repeat (3) tick();
        chk_zero("reset_hold");
        rst = 1'b0;
        tick();
        chk_zero("after_reset");

        rdack = 1'b1; wrack = 1'b1; err = 1'b1; ipdata = 32'hBAD0_BAD0;
        tick();
        rdack = 1'b0; wrack = 1'b0; err = 1'b0; ipdata = 32'h0;
        tick();
        chk_zero("idle_stray_ack");

        awaddr = 12'h500; awvalid = 1'b1;
        repeat (4) begin
            tick();
            chk("aw_only_waits", 32'({awready, wready, arready, cs}), 0);
        end
        awvalid = 1'b0;
        tick();

        // Contention right after reset: read, then write, then the re-asserted read
        araddr = 12'h200; arvalid = 1'b1;
        awaddr = 12'h300; wdata = 32'hA5A5_0001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        push_exp(1'b0, 2'b00, 32'h1111_1111);
        push_exp(1'b1, 2'b00, 32'h0);
        push_exp(1'b0, 2'b00, 32'h2222_2222);
        wait_grant(g);
        chk("rr_first_is_read", 32'(g), 1);
        chk("rr_first_aw_low", 32'(awready), 0);
        chk("rr_first_addr", 32'(bus_addr), 32'h200);
        rdack = 1'b1; ipdata = 32'h1111_1111;
        tick();
        rdack = 1'b0; ipdata = 32'h0; araddr = 12'h204;
        wait_grant(g);
        chk("rr_second_is_write", 32'(g), 0);
        chk("rr_second_addr", 32'(bus_addr), 32'h300);
        wrack = 1'b1;
        tick();
        wrack = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        wait_grant(g);
        chk("rr_third_is_read", 32'(g), 1);
        chk("rr_third_addr", 32'(bus_addr), 32'h204);
        rdack = 1'b1; ipdata = 32'h2222_2222;
        tick();
        rdack = 1'b0; arvalid = 1'b0; ipdata = 32'h0;
        wait_quiet();

        do_write(12'h404, 32'hDEAD_BEEF, 4'hF, 3, 1'b0, 1'b0);

        rready = 1'b0; araddr = 12'h600; arvalid = 1'b1;
        push_exp(1'b0, 2'b00, 32'h1234_5678);
        wait_grant(g);
        chk("hold_grant_read", 32'(g), 1);
        rdack = 1'b1; ipdata = 32'h1234_5678;
        tick();
        rdack = 1'b0; arvalid = 1'b0; ipdata = 32'hFFFF_FFFF;
        chk("hold_ce_drop", 32'({cs, rdce}), 0);
        chk("hold_rvalid", 32'(rvalid), 1);
        chk("hold_rdata", rdata, 32'h1234_5678);
        chk("hold_rresp", 32'(rresp), 0);
        repeat (5) begin
            tick();
            chk("hold_rvalid_held", 32'(rvalid), 1);
            chk("hold_rdata_stable", rdata, 32'h1234_5678);
        end
        rready = 1'b1;
        tick();
        chk("hold_rvalid_drop", 32'(rvalid), 0);
        ipdata = 32'h0;

        araddr = 12'h100; arvalid = 1'b1;
        push_exp(1'b0, 2'b10, 32'h0);
        wait_grant(g);
        chk("to_grant_read", 32'(g), 1);
        n = 1;
        tick();
        arvalid = 1'b0;
        while (rdce && n < 300) begin
            n++;
            tick();
        end
        chk("to_access_cycles", 32'(n), 64);
        chk("to_rvalid", 32'(rvalid), 1);
        chk("to_rresp", 32'(rresp), 2);
        chk("to_rdata_zero", rdata, 0);
        wait_quiet();

        do_read(12'h604, 2, 32'hCAFE_F00D);

        do_write(12'h40C, 32'h55AA_55AA, 4'h3, 3, 1'b1, 1'b1);

        awaddr = 12'h410; wdata = 32'h0F0F_0F0F; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        wait_grant(g);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("rst_pre_cs", 32'(cs), 1);
        rst = 1'b1;
        tick();
        chk_zero("rst_mid_access");
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("rst_no_bvalid", 32'(bvalid), 0);
        end
        do_write(12'h414, 32'h0BAD_F00D, 4'hF, 2, 1'b0, 1'b0);

        tick();
        chk("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
